// File: rtl/colision_scheduler.sv
// Time-multiplexed collision scheduler: snapshots player/enemy positions on a frame tick,
// scans six enemy slots through one shared bounding-box comparator, then freezes after a hit.
module colision_scheduler #(
    parameter int unsigned CAR_W         = 16,
    parameter int unsigned CAR_H         = 32,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [5:0]  enemy_active,
    input  logic [47:0] enemy_x,
    input  logic [59:0] enemy_y,
    input  logic [7:0]  player_x,
    input  logic [9:0]  player_y,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        crash,
    output logic [2:0]  crash_slot,
    output logic        freeze
);

    localparam int unsigned N_SLOTS = 6;
    localparam int unsigned XW      = 8;
    localparam int unsigned YW      = 10;
    localparam int unsigned SW      = 3;
    localparam int unsigned CW      = 8;

    localparam logic [XW-1:0] CAR_W_L    = XW'(CAR_W);
    localparam logic [YW-1:0] CAR_H_L    = YW'(CAR_H);
    localparam logic [CW-1:0] FREEZE_L   = CW'(FREEZE_FRAMES);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(N_SLOTS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SNAP   = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_CRASH  = 3'd4;

    logic [2:0]    state, state_n;
    logic [SW-1:0] slot, slot_n;
    logic          hit, hit_n;
    logic [SW-1:0] pend, pend_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] crash_slot_n;
    logic          freeze_n;
    logic          scan_busy_n;
    logic          scan_done_n;
    logic          crash_n;
    logic          snap_en;

    logic [XW-1:0]      snap_x [N_SLOTS];
    logic [YW-1:0]      snap_y [N_SLOTS];
    logic [N_SLOTS-1:0] snap_act;
    logic [XW-1:0]      snap_px;
    logic [YW-1:0]      snap_py;

    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic          sel_act;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic          hit_c;

    // Shared comparator: select the current slot from the snapshot and test overlap.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_act = 1'b0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (slot == SW'(i)) begin
                sel_x   = snap_x[i];
                sel_y   = snap_y[i];
                sel_act = snap_act[i];
            end
        end
        dx    = (sel_x >= snap_px) ? (sel_x - snap_px) : (snap_px - sel_x);
        dy    = (sel_y >= snap_py) ? (sel_y - snap_py) : (snap_py - sel_y);
        hit_c = sel_act && (dx < CAR_W_L) && (dy < CAR_H_L);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        slot_n       = slot;
        hit_n        = hit;
        pend_n       = pend;
        cnt_n        = cnt;
        crash_slot_n = crash_slot;
        scan_done_n  = 1'b0;
        crash_n      = 1'b0;
        snap_en      = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    state_n = S_SNAP;
                end
            end
            S_SNAP: begin
                snap_en = 1'b1;
                hit_n   = 1'b0;
                slot_n  = '0;
                state_n = S_SCAN;
            end
            S_SCAN: begin
                if (hit_c && !hit) begin
                    hit_n  = 1'b1;
                    pend_n = slot;
                end
                if (slot == LAST_SLOT) begin
                    // Outputs are registered, so the report is prepared on the way into REPORT.
                    state_n     = S_REPORT;
                    scan_done_n = 1'b1;
                    if (hit || hit_c) begin
                        crash_n      = 1'b1;
                        crash_slot_n = hit ? pend : slot;
                        cnt_n        = FREEZE_L;
                    end
                end else begin
                    slot_n = slot + SW'(1);
                end
            end
            S_REPORT: begin
                state_n = hit ? S_CRASH : S_IDLE;
            end
            S_CRASH: begin
                if (frame_tick) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        freeze_n    = (state_n == S_CRASH);
        scan_busy_n = (state_n == S_SNAP) || (state_n == S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            slot       <= '0;
            hit        <= 1'b0;
            pend       <= '0;
            cnt        <= '0;
            crash_slot <= '0;
            freeze     <= 1'b0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
            crash      <= 1'b0;
            snap_act   <= '0;
            snap_px    <= '0;
            snap_py    <= '0;
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            hit        <= hit_n;
            pend       <= pend_n;
            cnt        <= cnt_n;
            crash_slot <= crash_slot_n;
            freeze     <= freeze_n;
            scan_busy  <= scan_busy_n;
            scan_done  <= scan_done_n;
            crash      <= crash_n;
            if (snap_en) begin
                snap_act <= enemy_active;
                snap_px  <= player_x;
                snap_py  <= player_y;
                for (int i = 0; i < int'(N_SLOTS); i++) begin
                    snap_x[i] <= enemy_x[XW*i +: XW];
                    snap_y[i] <= enemy_y[YW*i +: YW];
                end
            end
        end
    end

endmodule

// File: tb/tb_colision_scheduler.sv
// Self-checking bench for colision_scheduler: directed scenarios plus randomized scans
// checked against a first-hit bounding-box model.
module tb_colision_scheduler;

    localparam int CW = 16;
    localparam int CH = 32;
    localparam int FF = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [5:0]  enemy_active;
    logic [47:0] enemy_x;
    logic [59:0] enemy_y;
    logic [7:0]  player_x;
    logic [9:0]  player_y;
    logic        scan_busy;
    logic        scan_done;
    logic        crash;
    logic [2:0]  crash_slot;
    logic        freeze;

    int n_cmp = 0;
    int n_err = 0;
    int exp_slot = 0;

    colision_scheduler #(.CAR_W(CW), .CAR_H(CH), .FREEZE_FRAMES(FF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .enemy_active(enemy_active), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .player_x(player_x), .player_y(player_y),
        .scan_busy(scan_busy), .scan_done(scan_done), .crash(crash),
        .crash_slot(crash_slot), .freeze(freeze)
    );

    always #5 clk = ~clk;

    // Lowest active slot whose box overlaps the player, or -1.
    function automatic int ref_scan();
        for (int i = 0; i < 6; i++) begin
            int ex, ey, px, py, dx, dy;
            ex = int'(enemy_x[8*i +: 8]);
            ey = int'(enemy_y[10*i +: 10]);
            px = int'(player_x);
            py = int'(player_y);
            dx = (ex > px) ? ex - px : px - ex;
            dy = (ey > py) ? ey - py : py - ey;
            if (enemy_active[i] && dx < CW && dy < CH) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        step();
        reset = 1'b0;
        exp_slot = 0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Tick, then advance to the REPORT cycle (T+8).
    task automatic run_scan();
        pulse_tick();
        repeat (7) step();
    endtask

    task automatic set_all(input int x, input int y, input logic [5:0] act);
        for (int i = 0; i < 6; i++) begin
            enemy_x[8*i +: 8]   = 8'(x);
            enemy_y[10*i +: 10] = 10'(y);
        end
        enemy_active = act;
    endtask

    task automatic set_slot(input int i, input int x, input int y);
        enemy_x[8*i +: 8]   = 8'(x);
        enemy_y[10*i +: 10] = 10'(y);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_tick = 1'b1;
        step();
        n_cmp += 5;
        if (scan_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", scan_busy); end
        if (scan_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", scan_done); end
        if (crash !== 1'b0) begin n_err++; $display("FAIL rst_crash got %b exp 0", crash); end
        if (crash_slot !== 3'd0) begin n_err++; $display("FAIL rst_slot got %0d exp 0", crash_slot); end
        if (freeze !== 1'b0) begin n_err++; $display("FAIL rst_freeze got %b exp 0", freeze); end
        reset = 1'b0;
        frame_tick = 1'b0;
        exp_slot = 0;
        step();
        n_cmp++;
        if (scan_busy !== 1'b0) begin n_err++; $display("FAIL rst_tick_ignored busy got %b exp 0", scan_busy); end
    endtask

    task automatic test_no_hit();
        int e;
        player_x = 8'd100;
        player_y = 10'd400;
        set_all(0, 0, 6'h3f);
        e = ref_scan();
        pulse_tick();
        for (int c = 0; c < 7; c++) begin
            n_cmp += 2;
            if (scan_busy !== 1'b1) begin n_err++; $display("FAIL lat_busy c%0d got %b exp 1", c, scan_busy); end
            if (scan_done !== 1'b0) begin n_err++; $display("FAIL lat_early_done c%0d got %b exp 0", c, scan_done); end
            step();
        end
        n_cmp += 5;
        if (scan_done !== 1'b1) begin n_err++; $display("FAIL nohit_done got %b exp 1", scan_done); end
        if (crash !== (e >= 0)) begin n_err++; $display("FAIL nohit_crash got %b exp %b", crash, e >= 0); end
        if (freeze !== 1'b0) begin n_err++; $display("FAIL nohit_freeze got %b exp 0", freeze); end
        if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL nohit_slot got %0d exp %0d", crash_slot, exp_slot); end
        if (scan_busy !== 1'b0) begin n_err++; $display("FAIL nohit_busy got %b exp 0", scan_busy); end
        step();
        n_cmp += 2;
        if (scan_done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b exp 0", scan_done); end
        if (freeze !== 1'b0) begin n_err++; $display("FAIL nohit_idle_freeze got %b exp 0", freeze); end
    endtask

    task automatic test_single_hit();
        int e;
        set_all(0, 0, 6'h3f);
        set_slot(3, 110, 380);
        e = ref_scan();
        if (e >= 0) exp_slot = e;
        run_scan();
        n_cmp += 3;
        if (scan_done !== 1'b1) begin n_err++; $display("FAIL hit3_done got %b exp 1", scan_done); end
        if (crash !== (e >= 0)) begin n_err++; $display("FAIL hit3_crash got %b exp %b", crash, e >= 0); end
        if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL hit3_slot got %0d exp %0d", crash_slot, exp_slot); end
        step();
        n_cmp += 2;
        if (freeze !== 1'b1) begin n_err++; $display("FAIL hit3_freeze got %b exp 1", freeze); end
        if (crash !== 1'b0) begin n_err++; $display("FAIL hit3_crash_width got %b exp 0", crash); end
        do_reset();
    endtask

    task automatic test_boundary();
        int e;
        int bx[4] = '{116, 115, 100, 100};
        int by[4] = '{400, 400, 432, 431};
        player_x = 8'd100;
        player_y = 10'd400;
        for (int k = 0; k < 4; k++) begin
            set_all(0, 0, 6'h3f);
            set_slot(0, bx[k], by[k]);
            e = ref_scan();
            if (e >= 0) exp_slot = e;
            run_scan();
            n_cmp += 2;
            if (crash !== (e >= 0)) begin n_err++; $display("FAIL bound%0d_crash got %b exp %b", k, crash, e >= 0); end
            if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL bound%0d_slot got %0d exp %0d", k, crash_slot, exp_slot); end
            if (e >= 0) do_reset(); else step();
        end
    endtask

    task automatic test_priority();
        int e;
        player_x = 8'd100;
        player_y = 10'd400;
        for (int k = 0; k < 2; k++) begin
            set_all(0, 0, (k == 0) ? 6'h3f : 6'h3b);
            set_slot(2, 100, 400);
            set_slot(4, 105, 410);
            e = ref_scan();
            if (e >= 0) exp_slot = e;
            run_scan();
            n_cmp += 2;
            if (crash !== (e >= 0)) begin n_err++; $display("FAIL prio%0d_crash got %b exp %b", k, crash, e >= 0); end
            if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL prio%0d_slot got %0d exp %0d", k, crash_slot, exp_slot); end
            step();
            n_cmp++;
            if (crash !== 1'b0) begin n_err++; $display("FAIL prio%0d_single_pulse got %b exp 0", k, crash); end
            do_reset();
        end
    endtask

    task automatic test_freeze();
        int dones;
        player_x = 8'd50;
        player_y = 10'd200;
        set_all(0, 0, 6'h3f);
        set_slot(1, 55, 210);
        run_scan();
        n_cmp++;
        if (crash !== 1'b1) begin n_err++; $display("FAIL frz_crash got %b exp 1", crash); end
        step();
        for (int k = 1; k <= FF; k++) begin
            dones = 0;
            repeat (2) begin
                if (scan_done === 1'b1) dones++;
                step();
            end
            n_cmp += 2;
            if (freeze !== 1'b1) begin n_err++; $display("FAIL frz_pre_tick%0d got %b exp 1", k, freeze); end
            if (dones != 0) begin n_err++; $display("FAIL frz_done_in_crash%0d got %0d exp 0", k, dones); end
            pulse_tick();
            n_cmp += 2;
            if (freeze !== (k < FF)) begin n_err++; $display("FAIL frz_post_tick%0d got %b exp %b", k, freeze, k < FF); end
            if (scan_busy !== 1'b0) begin n_err++; $display("FAIL frz_tick%0d_no_scan got %b exp 0", k, scan_busy); end
        end
        step();
        pulse_tick();
        n_cmp++;
        if (scan_busy !== 1'b1) begin n_err++; $display("FAIL frz_tick4_scan got %b exp 1", scan_busy); end
        step();
        pulse_tick();
        dones = 0;
        repeat (20) begin
            if (scan_done === 1'b1) dones++;
            step();
        end
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL tick_in_scan_dones got %0d exp 1", dones); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        player_x = 8'd20;
        player_y = 10'd30;
        set_all(200, 900, 6'h3f);
        pulse_tick();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp += 2;
        if (scan_busy !== 1'b0) begin n_err++; $display("FAIL rscan_busy got %b exp 0", scan_busy); end
        if ({scan_done, crash, freeze, crash_slot} !== 6'd0) begin n_err++; $display("FAIL rscan_outs got %b exp 0", {scan_done, crash, freeze, crash_slot}); end
        step();
        n_cmp++;
        if (scan_busy !== 1'b0) begin n_err++; $display("FAIL rscan_idle got %b exp 0", scan_busy); end
        set_slot(5, 25, 40);
        exp_slot = ref_scan();
        run_scan();
        n_cmp += 2;
        if (crash !== 1'b1) begin n_err++; $display("FAIL rcrash_hit got %b exp 1", crash); end
        if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL rcrash_slot got %0d exp %0d", crash_slot, exp_slot); end
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_slot = 0;
        n_cmp += 2;
        if (freeze !== 1'b0) begin n_err++; $display("FAIL rcrash_freeze got %b exp 0", freeze); end
        if ({scan_busy, scan_done, crash, crash_slot} !== 6'd0) begin n_err++; $display("FAIL rcrash_outs got %b exp 0", {scan_busy, scan_done, crash, crash_slot}); end
        pulse_tick();
        n_cmp++;
        if (scan_busy !== 1'b1) begin n_err++; $display("FAIL rpost_busy got %b exp 1", scan_busy); end
        exp_slot = ref_scan();
        repeat (7) step();
        n_cmp += 3;
        if (scan_done !== 1'b1) begin n_err++; $display("FAIL rpost_done got %b exp 1", scan_done); end
        if (crash !== 1'b1) begin n_err++; $display("FAIL rpost_crash got %b exp 1", crash); end
        if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL rpost_slot got %0d exp %0d", crash_slot, exp_slot); end
        do_reset();
    endtask

    task automatic test_random();
        int e, px, py, v;
        for (int it = 0; it < 150; it++) begin
            px = int'($urandom_range(0, 255));
            py = int'($urandom_range(0, 1023));
            player_x = 8'(px);
            player_y = 10'(py);
            for (int i = 0; i < 6; i++) begin
                v = px + int'($urandom_range(0, 48)) - 24;
                v = (v < 0) ? 0 : ((v > 255) ? 255 : v);
                enemy_x[8*i +: 8] = 8'(v);
                v = py + int'($urandom_range(0, 80)) - 40;
                v = (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
                enemy_y[10*i +: 10] = 10'(v);
            end
            enemy_active = 6'($urandom);
            e = ref_scan();
            if (e >= 0) exp_slot = e;
            pulse_tick();
            step();
            // Snapshot already taken: scramble inputs and maybe tick mid-scan.
            enemy_x = {$urandom, 16'($urandom)};
            enemy_y = {$urandom, 28'($urandom)};
            player_x = 8'($urandom);
            player_y = 10'($urandom);
            enemy_active = 6'($urandom);
            frame_tick = 1'($urandom);
            step();
            frame_tick = 1'b0;
            repeat (5) step();
            n_cmp += 3;
            if (scan_done !== 1'b1) begin n_err++; $display("FAIL rnd%0d_done got %b exp 1", it, scan_done); end
            if (crash !== (e >= 0)) begin n_err++; $display("FAIL rnd%0d_crash got %b exp %b", it, crash, e >= 0); end
            if (crash_slot !== 3'(exp_slot)) begin n_err++; $display("FAIL rnd%0d_slot got %0d exp %0d", it, crash_slot, exp_slot); end
            step();
            if (e >= 0) begin
                for (int k = 0; k < FF; k++) begin
                    step();
                    pulse_tick();
                end
            end
            n_cmp++;
            if ({freeze, scan_busy} !== 2'b00) begin n_err++; $display("FAIL rnd%0d_idle got %b exp 00", it, {freeze, scan_busy}); end
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        enemy_active = '0;
        enemy_x = '0;
        enemy_y = '0;
        player_x = '0;
        player_y = '0;
        test_reset();
        test_no_hit();
        test_single_hit();
        test_boundary();
        test_priority();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
